// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: eight 32-bit registers, REG7 is a read-only count of completed OKAY writes.
// Define AXIL_ADDR_DECODE_ERR_EN to answer SLVERR for out-of-range/misaligned addresses and REG7 writes.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic                    s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic                    s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    output logic                    dbg_rd_state
);

    // Every channel transfers on a rising edge where valid and ready are both 1; the
    // slave's ready/valid outputs depend only on internal flops, never on master inputs.

    localparam int         NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] CNT_IDX   = 3'd7;

    typedef enum logic { RD_IDLE = 1'b0, RD_RESP = 1'b1 } rd_state_e;

    logic                  rdy_en_q, rdy_en_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NUM_BYTES-1:0]  w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic                  bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] regs_q [8];
    logic [DATA_WIDTH-1:0] regs_d [8];
    rd_state_e             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rresp_q, rresp_d;

    logic       aw_hs, w_hs, ar_hs, b_hs, commit;
    logic [2:0] wr_idx, rd_idx;
    logic       wr_err, rd_err, wr_counts;

    assign wr_idx = aw_addr_q[4:2];
    assign rd_idx = s0_axi_araddr[4:2];

`ifdef AXIL_ADDR_DECODE_ERR_EN
    assign wr_err = (aw_addr_q[ADDR_WIDTH-1:5] != '0) || (aw_addr_q[1:0] != 2'b00)
                    || (wr_idx == CNT_IDX);
    assign rd_err = (s0_axi_araddr[ADDR_WIDTH-1:5] != '0) || (s0_axi_araddr[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_q[ADDR_WIDTH-1:5], aw_addr_q[1:0],
                                s0_axi_araddr[ADDR_WIDTH-1:5], s0_axi_araddr[1:0]};
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // rdy_en_q keeps all readies low during reset and raises them on the first edge after it.
    assign rdy_en_d       = 1'b1;
    assign s0_axi_awready = rdy_en_q && !aw_full_q && !bvalid_q;
    assign s0_axi_wready  = rdy_en_q && !w_full_q && !bvalid_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = rresp_q;
    assign dbg_rd_state   = rd_state_q;

    assign aw_hs     = s0_axi_awvalid && s0_axi_awready;
    assign w_hs      = s0_axi_wvalid && s0_axi_wready;
    assign ar_hs     = s0_axi_arvalid && s0_axi_arready;
    assign b_hs      = bvalid_q && s0_axi_bready;
    assign commit    = aw_full_q && w_full_q;
    assign wr_counts = !wr_err && (wr_idx != CNT_IDX);

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = s0_axi_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s0_axi_wdata;
            w_strb_d = s0_axi_wstrb;
        end
        if (b_hs) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err;
            if (wr_counts) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (w_strb_q[i]) begin
                        regs_d[wr_idx][i*8 +: 8] = w_data_q[i*8 +: 8];
                    end
                end
                regs_d[CNT_IDX] = regs_q[CNT_IDX] + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rdy_en_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rd_state_q <= RD_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (s0_axi_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        s0_axi_arready = rdy_en_q && (rd_state_q == RD_IDLE);
        s0_axi_rvalid  = (rd_state_q == RD_RESP);
    end

    // Read data samples regs_q, so a same-edge write or count increment is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rresp_d = rd_err;
            rdata_d = rd_err ? '0 : regs_q[rd_idx];
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rdata_q <= '0;
            rresp_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave; expected values are hand-computed,
// with the AXIL_ADDR_DECODE_ERR_EN build selecting the alternate expectations.
module tb_axil_reg_slave;

`ifdef AXIL_ADDR_DECODE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bresp, bvalid, bready;
    logic [7:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic        rresp, rvalid, rready;
    logic        dbg_rd_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt;

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (rst_n),
        .s0_axi_awaddr  (awaddr),
        .s0_axi_awvalid (awvalid),
        .s0_axi_awready (awready),
        .s0_axi_wdata   (wdata),
        .s0_axi_wstrb   (wstrb),
        .s0_axi_wvalid  (wvalid),
        .s0_axi_wready  (wready),
        .s0_axi_bresp   (bresp),
        .s0_axi_bvalid  (bvalid),
        .s0_axi_bready  (bready),
        .s0_axi_araddr  (araddr),
        .s0_axi_arvalid (arvalid),
        .s0_axi_arready (arready),
        .s0_axi_rdata   (rdata),
        .s0_axi_rresp   (rresp),
        .s0_axi_rvalid  (rvalid),
        .s0_axi_rready  (rready),
        .dbg_rd_state   (dbg_rd_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw_w(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string tag);
        int   cyc;
        logic aw_hit, w_hit;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        cyc     = 0;
        while ((awvalid || wvalid) && cyc < 20) begin
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            tick();
            cyc++;
            if (aw_hit) awvalid = 1'b0;
            if (w_hit)  wvalid  = 1'b0;
        end
        check_eq({tag, ":aw_w_accepted"}, 32'(!awvalid && !wvalid), 32'd1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic wait_b(input logic exp_resp, input string tag);
        int cyc;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq({tag, ":bvalid"}, 32'(bvalid), 32'd1);
        check_eq({tag, ":bresp"}, 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq({tag, ":bvalid_clear"}, 32'(bvalid), 32'd0);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic exp_resp, input string tag);
        send_aw_w(addr, data, strb, tag);
        wait_b(exp_resp, tag);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic exp_resp, input int rready_delay, input string tag);
        int          cyc;
        logic [31:0] exp;
        exp_q.push_back(exp_data);
        araddr  = addr;
        arvalid = 1'b1;
        cyc     = 0;
        while (!arready && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq({tag, ":arready"}, 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check_eq({tag, ":rvalid_lat1"}, 32'(rvalid), 32'd1);
        for (int i = 0; i < rready_delay; i++) begin
            tick();
            check_eq({tag, ":hold_rvalid"}, 32'(rvalid), 32'd1);
            check_eq({tag, ":hold_arready"}, 32'(arready), 32'd0);
            check_eq({tag, ":hold_rdata"}, rdata, exp_data);
        end
        rready = 1'b1;
        exp    = exp_q.pop_front();
        check_eq({tag, ":rdata"}, rdata, exp);
        check_eq({tag, ":rresp"}, 32'(rresp), 32'(exp_resp));
        tick();
        rready = 1'b0;
        check_eq({tag, ":rvalid_clear"}, 32'(rvalid), 32'd0);
        check_eq({tag, ":arready_back"}, 32'(arready), 32'd1);
    endtask

    // Write whose commit edge coincides with a read handshake; the read must see old data.
    task automatic write_with_read(input logic [7:0] waddr, input logic [31:0] data,
                                   input logic [7:0] raddr, input logic [31:0] exp_rdata,
                                   input string tag);
        check_eq({tag, ":idle_awready"}, 32'(awready && wready), 32'd1);
        awaddr  = waddr;
        wdata   = data;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = raddr;
        arvalid = 1'b1;
        check_eq({tag, ":arready"}, 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check_eq({tag, ":rvalid"}, 32'(rvalid), 32'd1);
        check_eq({tag, ":bvalid"}, 32'(bvalid), 32'd1);
        check_eq({tag, ":rdata_old"}, rdata, exp_rdata);
        check_eq({tag, ":bresp"}, 32'(bresp), 32'd0);
        rready = 1'b1;
        bready = 1'b1;
        tick();
        rready = 1'b0;
        bready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        exp_cnt = '0;

        // Reset values
        #3;
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_wready", 32'(wready), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_bresp", 32'(bresp), 32'd0);
        check_eq("rst_rresp", 32'(rresp), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_rd_state", 32'(dbg_rd_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("pre_edge_awready", 32'(awready), 32'd0);
        tick();
        check_eq("post_rst_awready", 32'(awready), 32'd1);
        check_eq("post_rst_wready", 32'(wready), 32'd1);
        check_eq("post_rst_arready", 32'(arready), 32'd1);

        // AW and W in the same cycle
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 1'b0, "wr04");
        exp_cnt = exp_cnt + 1;
        axi_read(8'h04, 32'hDEADBEEF, 1'b0, 0, "rd04");
        axi_read(8'h1C, 32'd1, 1'b0, 0, "rd_cnt1");

        // W three cycles ahead of AW, partial strobe over 0xAAAAAAAA
        axi_write(8'h08, 32'hAAAAAAAA, 4'hF, 1'b0, "wr08_init");
        exp_cnt = exp_cnt + 1;
        wdata  = 32'h11223344;
        wstrb  = 4'h3;
        wvalid = 1'b1;
        check_eq("early_w_wready", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        check_eq("early_w_buf_full", 32'(wready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("early_w_no_b", 32'(bvalid), 32'd0);
            tick();
        end
        awaddr  = 8'h08;
        awvalid = 1'b1;
        check_eq("late_aw_awready", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        wait_b(1'b0, "wr08_part");
        exp_cnt = exp_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            check_eq("single_b", 32'(bvalid), 32'd0);
            tick();
        end
        axi_read(8'h08, 32'hAAAA3344, 1'b0, 0, "rd08_part");

        // B back-pressure: bready low for 5 cycles with a second AW waiting
        send_aw_w(8'h0C, 32'h12345678, 4'hF, "wr0c");
        exp_cnt = exp_cnt + 1;
        tick();
        check_eq("bp_bvalid_up", 32'(bvalid), 32'd1);
        awaddr  = 8'h10;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_bvalid", 32'(bvalid), 32'd1);
            check_eq("bp_bresp", 32'(bresp), 32'd0);
            check_eq("bp_awready", 32'(awready), 32'd0);
            check_eq("bp_wready", 32'(wready), 32'd0);
            tick();
        end
        bready = 1'b1;
        check_eq("bp_awready_last", 32'(awready), 32'd0);
        tick();
        bready = 1'b0;
        check_eq("bp_bvalid_clear", 32'(bvalid), 32'd0);
        check_eq("bp_awready_after", 32'(awready), 32'd1);
        axi_write(8'h10, 32'hCAFEF00D, 4'hF, 1'b0, "wr10");
        exp_cnt = exp_cnt + 1;
        axi_read(8'h0C, 32'h12345678, 1'b0, 0, "rd0c");
        axi_read(8'h10, 32'hCAFEF00D, 1'b0, 0, "rd10");

        // Zero strobe counts but leaves data; REG7 writes are dropped
        axi_write(8'h14, 32'hFFFFFFFF, 4'h0, 1'b0, "wr14_nostrb");
        exp_cnt = exp_cnt + 1;
        axi_read(8'h14, 32'd0, 1'b0, 0, "rd14");
        axi_write(8'h1C, 32'h0000FFFF, 4'hF, ERR_EN, "wr1c");
        axi_read(8'h1C, exp_cnt, 1'b0, 0, "rd_cnt_after_wr1c");

        // Out-of-range address: SLVERR with decode errors, alias of REG0 without
        axi_write(8'h40, 32'h00000055, 4'hF, ERR_EN, "wr40");
        exp_cnt = exp_cnt + (ERR_EN ? 32'd0 : 32'd1);
        axi_read(8'h00, ERR_EN ? 32'd0 : 32'h55, 1'b0, 0, "rd00");
        axi_read(8'h41, ERR_EN ? 32'd0 : 32'h55, ERR_EN, 0, "rd41");

        // Read and write completing on the same edge
        axi_write(8'h18, 32'h66666666, 4'hF, 1'b0, "wr18_a");
        exp_cnt = exp_cnt + 1;
        write_with_read(8'h18, 32'h77777777, 8'h18, 32'h66666666, "same_edge_data");
        exp_cnt = exp_cnt + 1;
        axi_read(8'h18, 32'h77777777, 1'b0, 0, "rd18_new");
        write_with_read(8'h18, 32'h88888888, 8'h1C, exp_cnt, "same_edge_cnt");
        exp_cnt = exp_cnt + 1;
        axi_read(8'h1C, exp_cnt, 1'b0, 0, "rd_cnt_post_inc");

        // Bring the count to 20, then read it with rready held off for 4 cycles
        while (exp_cnt < 32'd20) begin
            axi_write(8'h18, 32'h100 + exp_cnt, 4'hF, 1'b0, "wr_fill");
            exp_cnt = exp_cnt + 1;
        end
        axi_read(8'h1C, 32'd20, 1'b0, 4, "rd_cnt20");

        // Reset with an R response pending and a W buffered
        wdata  = 32'h99999999;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        check_eq("mid_w_wready", 32'(wready), 32'd1);
        tick();
        wvalid  = 1'b0;
        araddr  = 8'h04;
        arvalid = 1'b1;
        check_eq("mid_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check_eq("mid_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'd0);
        check_eq("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("mid_rst_awready", 32'(awready), 32'd0);
        check_eq("mid_rst_arready", 32'(arready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rerst_awready", 32'(awready), 32'd1);
        check_eq("rerst_wready", 32'(wready), 32'd1);
        awaddr  = 8'h00;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("no_stray_b", 32'(bvalid), 32'd0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(i * 4), 32'd0, 1'b0, 0, "rd_after_rst");
        end

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the byte address width.
REQ-003 SHALL have port s0_axi_aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port s0_axi_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have write-address ports s0_axi_awaddr (input, ADDR_WIDTH), s0_axi_awvalid (input, 1) and s0_axi_awready (output, 1).
REQ-006 SHALL have write-data ports s0_axi_wdata (input, DATA_WIDTH), s0_axi_wstrb (input, DATA_WIDTH/8), s0_axi_wvalid (input, 1) and s0_axi_wready (output, 1).
REQ-007 SHALL have write-response ports s0_axi_bresp (output, 1; 0=OKAY, 1=SLVERR), s0_axi_bvalid (output, 1) and s0_axi_bready (input, 1).
REQ-008 SHALL have read-address ports s0_axi_araddr (input, ADDR_WIDTH), s0_axi_arvalid (input, 1) and s0_axi_arready (output, 1).
REQ-009 SHALL have read-data ports s0_axi_rdata (output, DATA_WIDTH), s0_axi_rresp (output, 1; 0=OKAY, 1=SLVERR), s0_axi_rvalid (output, 1) and s0_axi_rready (input, 1).

Function
REQ-010 SHALL be an AXI-Lite responder holding 8 word registers at byte addresses 0x00-0x1C, decoded on addr[4:2] with addr[1:0] ignored.
REQ-011 SHALL treat REG0-REG6 as read/write and REG7 as a read-only 32-bit count of completed OKAY writes, wrapping 0xFFFFFFFF->0.
REQ-012 SHALL accept AW and W independently, each into a one-entry holding buffer; awready=1 iff the AW buffer is empty and no B is pending; wready likewise for the W buffer.
REQ-013 SHALL accept AW and W presented in the same cycle, or in either order, and SHALL hold buffered values until the pair is complete.
REQ-014 SHALL commit the write in the cycle after both buffers are full: set bvalid, apply wstrb per byte lane, clear both buffers.
REQ-015 SHALL keep bvalid and bresp stable until the bready handshake; awready/wready SHALL stay 0 while bvalid=1.
REQ-016 SHALL ignore writes to REG7 (no data change, no count increment), responding bresp=0 when decode errors are disabled.
REQ-017 SHALL leave the target register unchanged when wstrb=0 but still count the write and return OKAY.
REQ-018 SHALL implement read states IDLE (arready=1) and RESP (rvalid=1, arready=0); an arvalid handshake in IDLE moves to RESP on the next edge with rdata latched.
REQ-019 SHALL hold rdata/rresp stable in RESP until rready=1, then return to IDLE; one read is outstanding at most.
REQ-020 SHALL give a read latency of 1 cycle from the AR handshake to rvalid.
REQ-021 SHALL return the pre-write register value when a read and a write to the same register complete on the same edge.
REQ-022 SHALL increment REG7 on the write-commit edge, so a read accepted on that edge returns the pre-increment count.

Reset
REQ-023 SHALL, while s0_axi_aresetn=0, drive awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0 and rdata=0, clear REG0-REG7 and both buffers, and put the read FSM in IDLE.
REQ-024 SHALL, when reset asserts mid-transaction, discard any buffered write and any pending B or R response without committing it.
REQ-025 SHALL raise awready, wready and arready on the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with AXIL_ADDR_DECODE_ERR_EN defined, respond SLVERR with no register side effect to any address with addr[ADDR_WIDTH-1:5]!=0 or addr[1:0]!=0, and to writes to REG7, returning rdata=0 on failing reads.
REQ-027 SHALL, with AXIL_ADDR_DECODE_ERR_EN undefined, alias addresses on addr[4:2] only, always respond OKAY, and silently drop writes to REG7.

Verification
REQ-028 SHALL cover: AW=0x04 and W=0xDEADBEEF with wstrb=0xF in the same cycle, then read 0x04 -> bresp=0, rdata=0xDEADBEEF, REG7=1.
REQ-029 SHALL cover: W=0x11223344 issued 3 cycles before AW=0x08 with wstrb=0x3 over an old value 0xAAAAAAAA -> REG2=0xAAAA3344, one B only.
REQ-030 SHALL cover: bready held 0 for 5 cycles after bvalid -> bvalid stays 1, awready=wready=0, second AW not accepted until the B handshake.
REQ-031 SHALL cover: read 0x1C after 20 writes, with rready delayed 4 cycles -> rdata=20 held stable, arready=0 throughout.
REQ-032 SHALL cover: write 0x40 with the macro defined -> bresp=1, REG0 unchanged; without the macro -> REG0 updated, bresp=0.
REQ-033 SHALL cover: reset pulsed while rvalid=1 and a W is buffered -> rvalid=0 immediately, all registers read 0, no stray B afterward.
